// File: rtl/buz_sched_if.sv
// -----------------------------------------------------------------------------
// buz_sched_if
// Purpose : groups the request/alarm signals of the buzzer scheduler.
// Signals : req   [2:0] per-requester job request (bit 2 highest priority)
//           mute        level, silences buzz only
//           buzz        registered buzzer drive
//           relay       registered relay drive
//           gnt   [2:0] registered one-hot grant of the active job
//           busy        registered, high while a job or its gap is running
//           done        registered one-cycle pulse on normal job completion
// Modports: master = request source (drives req/mute)
//           slave  = scheduler (drives buzz/relay/gnt/busy/done)
// -----------------------------------------------------------------------------
interface buz_sched_if;
   logic [2:0] req;
   logic       mute;
   logic       buzz;
   logic       relay;
   logic [2:0] gnt;
   logic       busy;
   logic       done;

   modport master (
      output req,
      output mute,
      input  buzz,
      input  relay,
      input  gnt,
      input  busy,
      input  done
   );

   modport slave (
      input  req,
      input  mute,
      output buzz,
      output relay,
      output gnt,
      output busy,
      output done
   );
endinterface

// File: rtl/buz_sched.sv
// -----------------------------------------------------------------------------
// buz_sched
// Purpose : priority scheduler for three buzzer/relay alarm jobs. Each job k
//           plays BEEPSk ON/OFF pairs of HALF_Pk cycles per half, followed by
//           GAP_CYC silent cycles. Requests are latched in a pending register
//           and served highest bit first, one job at a time.
// Ports   : i_clk    system clock, all state on the rising edge
//           i_rst_n  asynchronous active-low reset
//           bus      buz_sched_if.slave (req, mute in; buzz, relay, gnt,
//                    busy, done out; all outputs registered)
// Config  : BUZ_SCHED_PREEMPT_EN defined -> a pending request above the active
//           grant aborts the running job (no DONE, no GAP) and starts at once.
//           Undefined (default) -> no preemption.
// -----------------------------------------------------------------------------
module buz_sched #(
   parameter int unsigned HALF_P0 = 50000000,
   parameter int unsigned HALF_P1 = 25000000,
   parameter int unsigned HALF_P2 = 12500000,
   parameter int unsigned BEEPS0  = 2,
   parameter int unsigned BEEPS1  = 3,
   parameter int unsigned BEEPS2  = 4,
   parameter int unsigned GAP_CYC = 5000000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   buz_sched_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   // Last count value of each phase (counters run 0 .. N-1)
   localparam logic [25:0] HALF_LAST0 = 26'(HALF_P0 - 1);
   localparam logic [25:0] HALF_LAST1 = 26'(HALF_P1 - 1);
   localparam logic [25:0] HALF_LAST2 = 26'(HALF_P2 - 1);
   localparam logic [25:0] GAP_LAST   = 26'(GAP_CYC - 1);
   localparam logic [3:0]  BEEPS0_W   = 4'(BEEPS0);
   localparam logic [3:0]  BEEPS1_W   = 4'(BEEPS1);
   localparam logic [3:0]  BEEPS2_W   = 4'(BEEPS2);

   logic [1:0]  r_state;
   logic [2:0]  r_pend;
   logic [1:0]  r_idx;
   logic [25:0] r_pcnt;
   logic [3:0]  r_bcnt;
   logic        r_buzz;
   logic        r_relay;
   logic [2:0]  r_gnt;
   logic        r_busy;
   logic        r_done;

   logic [1:0]  w_state_next;
   logic [2:0]  w_pend_next;
   logic [1:0]  w_idx_next;
   logic [25:0] w_pcnt_next;
   logic [3:0]  w_bcnt_next;
   logic [2:0]  w_gnt_next;
   logic        w_done_next;
   logic [2:0]  w_grant_clr;
   logic [1:0]  w_hi_idx;
   logic [25:0] w_half_last;
   logic [3:0]  w_beeps;
   logic [2:0]  w_above_mask;

   // Pending bits: a request in the same cycle as the grant wins over the
   // clear, so the same requester gets a fresh job later.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_pend
         assign w_pend_next[gi] = (r_pend[gi] & ~w_grant_clr[gi]) | bus.req[gi];
      end
   endgenerate

   // Highest pending requester
   always_comb begin
      w_hi_idx = 2'd0;
      if (r_pend[2])      w_hi_idx = 2'd2;
      else if (r_pend[1]) w_hi_idx = 2'd1;
   end

   // Timing of the currently granted requester
   always_comb begin
      w_half_last  = HALF_LAST0;
      w_beeps      = BEEPS0_W;
      w_above_mask = 3'b110;
      case (r_idx)
         2'd1: begin
            w_half_last  = HALF_LAST1;
            w_beeps      = BEEPS1_W;
            w_above_mask = 3'b100;
         end
         2'd2: begin
            w_half_last  = HALF_LAST2;
            w_beeps      = BEEPS2_W;
            w_above_mask = 3'b000;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_pcnt_next  = r_pcnt;
      w_bcnt_next  = r_bcnt;
      w_gnt_next   = r_gnt;
      w_done_next  = 1'b0;
      w_grant_clr  = 3'b000;

      case (r_state)
         ST_IDLE: begin
            if (|r_pend) begin
               w_state_next = ST_ON;
               w_idx_next   = w_hi_idx;
               w_gnt_next   = 3'b001 << w_hi_idx;
               w_grant_clr  = 3'b001 << w_hi_idx;
               w_pcnt_next  = '0;
               w_bcnt_next  = '0;
            end
         end
         ST_ON: begin
            if (r_pcnt == w_half_last) begin
               w_state_next = ST_OFF;
               w_pcnt_next  = '0;
            end else begin
               w_pcnt_next  = r_pcnt + 26'd1;
            end
         end
         ST_OFF: begin
            if (r_pcnt == w_half_last) begin
               w_pcnt_next = '0;
               if (r_bcnt + 4'd1 == w_beeps) begin
                  w_state_next = ST_GAP;
                  w_gnt_next   = 3'b000;
                  w_done_next  = 1'b1;
                  w_bcnt_next  = '0;
               end else begin
                  w_state_next = ST_ON;
                  w_bcnt_next  = r_bcnt + 4'd1;
               end
            end else begin
               w_pcnt_next = r_pcnt + 26'd1;
            end
         end
         default: begin // ST_GAP
            if (r_pcnt == GAP_LAST) begin
               w_state_next = ST_IDLE;
               w_pcnt_next  = '0;
            end else begin
               w_pcnt_next  = r_pcnt + 26'd1;
            end
         end
      endcase

`ifdef BUZ_SCHED_PREEMPT_EN
      // A higher pending requester overrides whatever the running job was
      // about to do; the aborted job is simply forgotten.
      if (((r_state == ST_ON) || (r_state == ST_OFF)) && ((r_pend & w_above_mask) != 3'b000)) begin
         w_state_next = ST_ON;
         w_idx_next   = w_hi_idx;
         w_gnt_next   = 3'b001 << w_hi_idx;
         w_grant_clr  = 3'b001 << w_hi_idx;
         w_pcnt_next  = '0;
         w_bcnt_next  = '0;
         w_done_next  = 1'b0;
      end
`endif
   end

   // Outputs are registered from the next state so they line up with it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_pend  <= '0;
         r_idx   <= '0;
         r_pcnt  <= '0;
         r_bcnt  <= '0;
         r_buzz  <= 1'b0;
         r_relay <= 1'b0;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pend  <= w_pend_next;
         r_idx   <= w_idx_next;
         r_pcnt  <= w_pcnt_next;
         r_bcnt  <= w_bcnt_next;
         r_buzz  <= (w_state_next == ST_ON) && !bus.mute;
         r_relay <= (w_state_next == ST_ON) || (w_state_next == ST_OFF);
         r_gnt   <= w_gnt_next;
         r_busy  <= (w_state_next != ST_IDLE);
         r_done  <= w_done_next;
      end
   end

   assign bus.buzz  = r_buzz;
   assign bus.relay = r_relay;
   assign bus.gnt   = r_gnt;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule

// File: tb/tb_buz_sched.sv
// -----------------------------------------------------------------------------
// tb_buz_sched
// Purpose : self-checking bench for buz_sched with small timing parameters.
//           A job-timeline reference model (start time + arithmetic) predicts
//           every output each cycle; directed scenarios are followed by
//           randomized requests, mute and resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_buz_sched;

   localparam int HP0 = 4, HP1 = 3, HP2 = 2;
   localparam int BP0 = 2, BP1 = 1, BP2 = 3;
   localparam int GAPC = 5;

   logic clk;
   logic rst_n;

   buz_sched_if bus_if ();

   buz_sched #(
      .HALF_P0 (HP0),
      .HALF_P1 (HP1),
      .HALF_P2 (HP2),
      .BEEPS0  (BP0),
      .BEEPS1  (BP1),
      .BEEPS2  (BP2),
      .GAP_CYC (GAPC)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int half_tab [3] = '{HP0, HP1, HP2};
   int beep_tab [3] = '{BP0, BP1, BP2};

   int       cyc;
   int       m_kind;     // 0 idle, 1 job, 2 gap
   int       m_job;
   int       m_start;
   int       m_gstart;
   bit [2:0] m_pend;
   bit       e_buzz, e_relay, e_busy, e_done;
   bit [2:0] e_gnt;

   function automatic int hi_bit(input bit [2:0] p);
      if (p[2]) return 2;
      if (p[1]) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_kind = 0;
      m_pend = '0;
      e_buzz = 0; e_relay = 0; e_busy = 0; e_done = 0; e_gnt = '0;
   endtask

   task automatic start_job(input int k);
      m_kind  = 1;
      m_job   = k;
      m_start = cyc;
      m_pend[k] = 1'b0;
   endtask

   task automatic model_step(input bit [2:0] r, input bit m);
      bit [2:0] old;
      bit       preempted;
      int       t;
      cyc++;
      old = m_pend;
      preempted = 0;
      case (m_kind)
         0: if (old != 0) start_job(hi_bit(old));
         1: begin
`ifdef BUZ_SCHED_PREEMPT_EN
            if (old != 0 && hi_bit(old) > m_job) begin
               $display("job %0d preempted by job %0d at cycle %0d", m_job, hi_bit(old), cyc);
               start_job(hi_bit(old));
               preempted = 1;
            end
`endif
            if (!preempted && (cyc - m_start) == 2 * half_tab[m_job] * beep_tab[m_job]) begin
               m_kind   = 2;
               m_gstart = cyc;
               $display("job %0d done at cycle %0d", m_job, cyc);
            end
         end
         default: if (cyc - m_gstart == GAPC) m_kind = 0;
      endcase
      m_pend = m_pend | r;

      e_buzz = 0; e_relay = 0; e_busy = 0; e_done = 0; e_gnt = '0;
      if (m_kind == 1) begin
         t       = cyc - m_start;
         e_relay = 1;
         e_busy  = 1;
         e_gnt   = 3'b001 << m_job;
         e_buzz  = (((t / half_tab[m_job]) % 2) == 0) && !m;
      end else if (m_kind == 2) begin
         e_busy = 1;
         e_done = (cyc == m_gstart);
      end
   endtask

   task automatic check_outputs();
      check("buzz",  32'(bus_if.buzz),  32'(e_buzz));
      check("relay", 32'(bus_if.relay), 32'(e_relay));
      check("gnt",   32'(bus_if.gnt),   32'(e_gnt));
      check("busy",  32'(bus_if.busy),  32'(e_busy));
      check("done",  32'(bus_if.done),  32'(e_done));
   endtask

   // One clock cycle: drive inputs after a falling edge, model the rising
   // edge, compare at the next falling edge.
   task automatic cycle(input bit [2:0] r, input bit m);
      bus_if.req  = r;
      bus_if.mute = m;
      @(posedge clk);
      model_step(r, m);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_cycles(input int n, input bit m);
      for (int i = 0; i < n; i++) cycle(3'b000, m);
   endtask

   // Reset asserted mid-cycle, with requests held high during reset
   task automatic mid_reset();
      #2;
      bus_if.req = 3'b111;
      rst_n = 1'b0;
      #1;
      check("rst_buzz",  32'(bus_if.buzz),  32'd0);
      check("rst_relay", 32'(bus_if.relay), 32'd0);
      check("rst_gnt",   32'(bus_if.gnt),   32'd0);
      check("rst_busy",  32'(bus_if.busy),  32'd0);
      check("rst_done",  32'(bus_if.done),  32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.req = 3'b000;
   endtask

   int       done_cnt;
   int       gnt_seq [$];
   bit [2:0] last_gnt;
   bit [2:0] rr;
   bit       mm;

   initial begin
      rst_n       = 1'b0;
      bus_if.req  = 3'b000;
      bus_if.mute = 1'b0;
      cyc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Single job-0 pulse: 4 on / 4 off x2, DONE, then 5-cycle gap
      cycle(3'b001, 0);
      idle_cycles(30, 0);

      // All three at once: served 100, 010, 001 with three DONE pulses
      done_cnt = 0;
      gnt_seq.delete();
      last_gnt = '0;
      cycle(3'b111, 0);
      for (int i = 0; i < 80; i++) begin
         cycle(3'b000, 0);
         if (bus_if.done) done_cnt++;
         if (bus_if.gnt != 3'b000 && bus_if.gnt != last_gnt) gnt_seq.push_back(int'(bus_if.gnt));
         last_gnt = bus_if.gnt;
      end
      check("done_count", 32'(done_cnt), 32'd3);
      check("gnt_jobs", 32'(gnt_seq.size()), 32'd3);
      if (gnt_seq.size() == 3) begin
         check("gnt_first",  32'(gnt_seq[0]), 32'd4);
         check("gnt_second", 32'(gnt_seq[1]), 32'd2);
         check("gnt_third",  32'(gnt_seq[2]), 32'd1);
      end

      // Job 1 fully muted: buzz stays low, relay and DONE unaffected
      cycle(3'b010, 1);
      idle_cycles(15, 1);

      // Reset during the OFF phase of job 0
      cycle(3'b001, 0);
      idle_cycles(7, 0);
      mid_reset();
      idle_cycles(5, 0);

      // Job 2 requested during the first ON of job 0
      cycle(3'b001, 0);
      idle_cycles(2, 0);
      cycle(3'b100, 0);
      idle_cycles(45, 0);

      // Requester 0 re-requests exactly on the edge it is granted
      cycle(3'b001, 0);
      cycle(3'b001, 0);
      idle_cycles(50, 0);

      // Randomized traffic
      mm = 0;
      for (int i = 0; i < 4000; i++) begin
         rr[0] = ($urandom_range(0, 24) == 0);
         rr[1] = ($urandom_range(0, 29) == 0);
         rr[2] = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 15) == 0) mm = ~mm;
         cycle(rr, mm);
         if ($urandom_range(0, 799) == 0) mid_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/buz_sched.md
BUZ_SCHED -- requirements
Module: buz_sched

Interface
REQ-001 Parameter HALF_P0, default 50000000: ON/OFF half-period in CLK cycles for requester 0.
REQ-002 Parameter HALF_P1, default 25000000: half-period for requester 1.
REQ-003 Parameter HALF_P2, default 12500000: half-period for requester 2.
REQ-004 Parameters BEEPS0/BEEPS1/BEEPS2, defaults 2/3/4: ON/OFF pairs per job; legal range 1..15.
REQ-005 Parameter GAP_CYC, default 5000000: silent cycles after every completed job.
REQ-006 CLK  input  1  system clock, all state on rising edge.
REQ-007 RESET_N  input  1  asynchronous active-low reset.
REQ-008 REQ  input  3  per-requester job request, sampled each cycle; bit 2 is highest priority.
REQ-009 MUTE  input  1  level; silences Buzz only.
REQ-010 Buzz  output  1  registered buzzer drive.
REQ-011 Relay  output  1  registered relay drive.
REQ-012 GNT  output  3  registered one-hot grant of the active job; 0 when no job is active.
REQ-013 BUSY  output  1  registered; high in ON, OFF and GAP.
REQ-014 DONE  output  1  registered one-cycle pulse on normal job completion.

Function
REQ-015 Pending register PEND[2:0]: bit k sets when REQ[k]=1, clears when job k is granted; set and clear in the same cycle leaves the bit set.
REQ-016 States IDLE, ON, OFF, GAP; 26-bit phase counter PCNT and 4-bit pair counter BCNT.
REQ-017 IDLE with PEND≠0: the next cycle enters ON for the highest set bit k; GNT=one-hot(k), PCNT=0, BCNT=0.
REQ-018 IDLE->ON latency: 1 cycle from the first cycle PEND is non-zero; a REQ pulse in IDLE therefore gives Buzz high 2 cycles later.
REQ-019 ON: Buzz=~MUTE, Relay=1; after HALF_Pk cycles in ON, enter OFF with PCNT=0.
REQ-020 OFF: Buzz=0, Relay=1; after HALF_Pk cycles, BCNT increments; if BCNT reaches BEEPSk, assert DONE for one cycle, clear GNT and enter GAP, else enter ON.
REQ-021 GAP: Buzz=0, Relay=0, GNT=0; after GAP_CYC cycles, enter IDLE; REQs arriving in GAP are still latched in PEND.
REQ-022 Total ON+OFF duration of job k is exactly 2*HALF_Pk*BEEPSk cycles.
REQ-023 A request for the active requester during its job only sets PEND and is served as a new job later.
REQ-024 MUTE affects Buzz in the same cycle it is registered; PCNT, BCNT, Relay and state are unaffected.
REQ-025 Simultaneous REQ bits are granted in descending priority, one job at a time.

Reset
REQ-026 RESET_N=0 asynchronously forces IDLE, PEND=0, PCNT=0, BCNT=0, Buzz=0, Relay=0, GNT=0, BUSY=0, DONE=0.
REQ-027 Reset mid-job abandons the job without a DONE pulse; requests held during reset are ignored.
REQ-028 After RESET_N rises, the first REQ sampled is on the first rising CLK edge.

Configuration
REQ-029 Macro BUZ_SCHED_PREEMPT_EN defined: in ON or OFF, if PEND has a bit above the current grant, the next cycle starts that job in ON with counters cleared. The aborted job is dropped with no DONE pulse and no GAP.
REQ-030 Macro undefined: no preemption; higher-priority requests wait in PEND until IDLE.

Verification (HALF_P0=4, HALF_P1=3, HALF_P2=2, BEEPS0=2, BEEPS1=1, BEEPS2=3, GAP_CYC=5)
REQ-031 1-cycle REQ=001 in IDLE -> Buzz high 2 cycles later, pattern 4 on/4 off x2, DONE one cycle after the last OFF, BUSY falls 5 cycles later.
REQ-032 REQ=111 in one cycle -> GNT order 100, 010, 001, each job separated by a 5-cycle GAP, 3 DONE pulses.
REQ-033 MUTE=1 throughout a job-1 request -> Buzz constantly 0, Relay high 6 cycles, DONE still pulses.
REQ-034 RESET_N low during the OFF phase of job 0 -> all outputs 0 immediately, no DONE, IDLE after release.
REQ-035 Job 0 active, REQ=100 during its first ON -> with BUZ_SCHED_PREEMPT_EN: GNT becomes 100 the next cycle and job 0 gives no DONE; without it: job 0 completes, then GAP, then job 2.
REQ-036 REQ[0] pulsed in the cycle job 0 is granted from IDLE -> job 0 runs twice back to back, separated by GAP.
